el2_dbg_cmd_seq: RTL and testbench

EL2_DBG_CMD_SEQ -- requirements
Module: el2_dbg_cmd_seq

---
 rtl/el2_dbg_cmd_seq.sv | 162 ++++++++++++++++
 tb/tb_el2_dbg_cmd_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_dbg_cmd_seq.sv
// Debug command sequencer: accepts one debug-module request, injects it into the
// decode stage, waits for completion and returns a response. Optional timeout: EL2_DBG_CMD_TIMEOUT_EN.
module el2_dbg_cmd_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_halted,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        dbg_cmd_valid,
    output logic        dbg_cmd_write,
    output logic [1:0]  dbg_cmd_type,
    output logic [31:0] dbg_cmd_addr,
    output logic [31:0] dbg_cmd_wrdata,
    input  logic        dec_dbg_cmd_done,
    input  logic        dec_dbg_cmd_fail,
    input  logic [31:0] dec_dbg_rddata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_fail,
    output logic        rsp_timeout,
    output logic [31:0] rsp_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        cmd_write_q, cmd_write_d;
    logic [1:0]  cmd_type_q, cmd_type_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;
    logic        rsp_fail_q, rsp_fail_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        accept;
    logic        legal;
    logic        timeout_hit;
    logic [31:0] done_data;

`ifdef EL2_DBG_CMD_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ISSUE) begin
            tmo_cnt_d = 16'd0;
        end else if ((state_q == WAIT) && (tmo_cnt_q != 16'hFFFF)) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (state_q == WAIT) && (tmo_cnt_q == TIMEOUT_LIMIT);
`else
    assign timeout_hit = 1'b0;
`endif

    assign accept    = req_valid && (state_q == IDLE);
    assign legal     = ~req_type[1];
    // Read data is only meaningful for a successful read; everything else returns zero.
    assign done_data = (!cmd_write_q && !dec_dbg_cmd_fail) ? dec_dbg_rddata : 32'd0;

    always_comb begin
        state_d       = state_q;
        cmd_write_d   = cmd_write_q;
        cmd_type_d    = cmd_type_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_wdata_d   = cmd_wdata_q;
        rsp_fail_d    = rsp_fail_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_data_d    = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_write_d   = req_write;
                    cmd_type_d    = req_type;
                    cmd_addr_d    = req_addr;
                    cmd_wdata_d   = req_wdata;
                    rsp_timeout_d = 1'b0;
                    rsp_data_d    = 32'd0;
                    if (legal && core_halted) begin
                        state_d    = ISSUE;
                        rsp_fail_d = 1'b0;
                    end else begin
                        state_d    = RESP;
                        rsp_fail_d = 1'b1;
                    end
                end
            end
            ISSUE, WAIT: begin
                if (dec_dbg_cmd_done) begin
                    state_d    = RESP;
                    rsp_fail_d = dec_dbg_cmd_fail;
                    rsp_data_d = done_data;
                end else if (timeout_hit) begin
                    state_d       = RESP;
                    rsp_fail_d    = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = 32'd0;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cmd_write_q   <= 1'b0;
            cmd_type_q    <= 2'd0;
            cmd_addr_q    <= 32'd0;
            cmd_wdata_q   <= 32'd0;
            rsp_fail_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            cmd_write_q   <= cmd_write_d;
            cmd_type_q    <= cmd_type_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            rsp_fail_q    <= rsp_fail_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign dbg_cmd_valid  = (state_q == ISSUE);
    assign dbg_cmd_write  = cmd_write_q;
    assign dbg_cmd_type   = cmd_type_q;
    assign dbg_cmd_addr   = cmd_addr_q;
    assign dbg_cmd_wrdata = cmd_wdata_q;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_fail       = rsp_fail_q;
    assign rsp_timeout    = rsp_timeout_q;
    assign rsp_data       = rsp_data_q;

endmodule

// File: tb/tb_el2_dbg_cmd_seq.sv
// Directed bench for el2_dbg_cmd_seq: vector table plus back-pressure and reset sequences.
// Timeout vectors are included when EL2_DBG_CMD_TIMEOUT_EN is defined.
module tb_el2_dbg_cmd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_halted;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        dbg_cmd_valid;
    logic        dbg_cmd_write;
    logic [1:0]  dbg_cmd_type;
    logic [31:0] dbg_cmd_addr;
    logic [31:0] dbg_cmd_wrdata;
    logic        dec_dbg_cmd_done;
    logic        dec_dbg_cmd_fail;
    logic [31:0] dec_dbg_rddata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_fail;
    logic        rsp_timeout;
    logic [31:0] rsp_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    el2_dbg_cmd_seq #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .core_halted      (core_halted),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_type         (req_type),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .dbg_cmd_valid    (dbg_cmd_valid),
        .dbg_cmd_write    (dbg_cmd_write),
        .dbg_cmd_type     (dbg_cmd_type),
        .dbg_cmd_addr     (dbg_cmd_addr),
        .dbg_cmd_wrdata   (dbg_cmd_wrdata),
        .dec_dbg_cmd_done (dec_dbg_cmd_done),
        .dec_dbg_cmd_fail (dec_dbg_cmd_fail),
        .dec_dbg_rddata   (dec_dbg_rddata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_fail         (rsp_fail),
        .rsp_timeout      (rsp_timeout),
        .rsp_data         (rsp_data)
    );

    typedef struct {
        string       name;
        logic [1:0]  typ;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        halted;
        int          n;          // done arrives n cycles after ISSUE; -1 = never
        logic        fail_in;
        logic [31:0] rddata;
        int          exp_pulses;
        logic        exp_fail;
        logic        exp_tmo;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [1:0] typ, logic wr, logic [31:0] addr,
                                logic [31:0] wdata, logic halted, int n, logic fail_in,
                                logic [31:0] rddata, int exp_pulses, logic exp_fail,
                                logic exp_tmo, logic [31:0] exp_data, int exp_lat);
        vec_t v;
        v.name = name; v.typ = typ; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.halted = halted; v.n = n; v.fail_in = fail_in; v.rddata = rddata;
        v.exp_pulses = exp_pulses; v.exp_fail = exp_fail; v.exp_tmo = exp_tmo;
        v.exp_data = exp_data; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(vec_t v);
        int pulses;
        int lat;
        pulses = 0;
        lat    = -1;
        core_halted = v.halted;
        req_type    = v.typ;
        req_write   = v.wr;
        req_addr    = v.addr;
        req_wdata   = v.wdata;
        req_valid   = 1'b1;
        rsp_ready   = 1'b1;
        chk({v.name, " req_ready"}, 32'(req_ready), 32'd1);
        tick();
        // Scramble the request bus: the captured command must not follow it.
        req_valid = 1'b0;
        req_type  = ~v.typ;
        req_write = ~v.wr;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        for (int c = 1; c <= 30; c++) begin
            if (dbg_cmd_valid) begin
                pulses++;
                chk({v.name, " cmd_addr"}, dbg_cmd_addr, v.addr);
                chk({v.name, " cmd_wdata"}, dbg_cmd_wrdata, v.wdata);
                chk({v.name, " cmd_type_write"}, {29'd0, dbg_cmd_type, dbg_cmd_write},
                    {29'd0, v.typ, v.wr});
            end
            dec_dbg_cmd_done = (v.n >= 0) && (c == 1 + v.n);
            dec_dbg_cmd_fail = dec_dbg_cmd_done && v.fail_in;
            dec_dbg_rddata   = dec_dbg_cmd_done ? v.rddata : 32'h5A5A_5A5A;
            if (rsp_valid) begin
                lat = c;
                break;
            end
            tick();
        end
        chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, " pulses"}, 32'(pulses), 32'(v.exp_pulses));
        chk({v.name, " rsp_fail"}, 32'(rsp_fail), 32'(v.exp_fail));
        chk({v.name, " rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_tmo));
        chk({v.name, " rsp_data"}, rsp_data, v.exp_data);
        tick();
        dec_dbg_cmd_done = 1'b0;
        dec_dbg_cmd_fail = 1'b0;
        chk({v.name, " idle_after"}, {30'd0, req_ready, rsp_valid}, 32'd2);
        chk({v.name, " cmd_addr_hold"}, dbg_cmd_addr, v.addr);
        $display("txn %s lat=%0d pulses=%0d fail=%0b tmo=%0b data=0x%08h",
                 v.name, lat, pulses, rsp_fail, rsp_timeout, rsp_data);
    endtask

    initial begin
        logic [31:0] held;
        rst = 1'b1;
        core_halted = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_type = 2'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        dec_dbg_cmd_done = 1'b0; dec_dbg_cmd_fail = 1'b0; dec_dbg_rddata = 32'd0;

        vecs.push_back(mk("gpr_rd_x5",   2'd0, 1'b0, 32'd5,     32'd0,    1'b1, 3, 1'b0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'hDEADBEEF, 5));
        vecs.push_back(mk("csr_wr_fail", 2'd1, 1'b1, 32'h7C4,   32'h1,    1'b1, 0, 1'b1, 32'h11111111, 1, 1'b1, 1'b0, 32'd0, 2));
        vecs.push_back(mk("mem_type2",   2'd2, 1'b0, 32'h1000,  32'd0,    1'b1, 0, 1'b0, 32'h22222222, 0, 1'b1, 1'b0, 32'd0, 1));
        vecs.push_back(mk("not_halted",  2'd0, 1'b0, 32'd3,     32'd0,    1'b0, 0, 1'b0, 32'h33333333, 0, 1'b1, 1'b0, 32'd0, 1));
        vecs.push_back(mk("csr_rd",      2'd1, 1'b0, 32'h300,   32'd0,    1'b1, 1, 1'b0, 32'h12345678, 1, 1'b0, 1'b0, 32'h12345678, 3));
        vecs.push_back(mk("gpr_wr",      2'd0, 1'b1, 32'd10,    32'hAA55, 1'b1, 2, 1'b0, 32'hFFFFFFFF, 1, 1'b0, 1'b0, 32'd0, 4));
        vecs.push_back(mk("rsvd_type3",  2'd3, 1'b1, 32'd1,     32'd9,    1'b1, 0, 1'b0, 32'h44444444, 0, 1'b1, 1'b0, 32'd0, 1));
        vecs.push_back(mk("gpr_rd_fail", 2'd0, 1'b0, 32'd31,    32'd0,    1'b1, 0, 1'b1, 32'h55555555, 1, 1'b1, 1'b0, 32'd0, 2));
`ifdef EL2_DBG_CMD_TIMEOUT_EN
        vecs.push_back(mk("timeout",     2'd0, 1'b0, 32'd6,     32'd0,    1'b1, -1, 1'b0, 32'd0,       1, 1'b1, 1'b1, 32'd0, 7));
        vecs.push_back(mk("done_wins",   2'd1, 1'b0, 32'h341,   32'd0,    1'b1, 5, 1'b0, 32'h0BADF00D, 1, 1'b0, 1'b0, 32'h0BADF00D, 7));
`else
        vecs.push_back(mk("long_wait",   2'd0, 1'b0, 32'd8,     32'd0,    1'b1, 8, 1'b0, 32'h600DCAFE, 1, 1'b0, 1'b0, 32'h600DCAFE, 10));
`endif

        // Reset state
        tick();
        chk("rst dbg_cmd_valid", 32'(dbg_cmd_valid), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst rsp_fields", {30'd0, rsp_fail, rsp_timeout}, 32'd0);
        chk("rst rsp_data", rsp_data, 32'd0);
        chk("rst cmd_addr", dbg_cmd_addr, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-pressure: response held for 5 cycles, late done must be ignored.
        core_halted = 1'b1; req_type = 2'd0; req_write = 1'b0; req_addr = 32'd7;
        req_valid = 1'b1; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        dec_dbg_cmd_done = 1'b1; dec_dbg_rddata = 32'hCAFEF00D;
        tick();
        dec_dbg_rddata = 32'h99999999; dec_dbg_cmd_fail = 1'b1;
        held = rsp_data;
        chk("bp rsp_data", held, 32'hCAFEF00D);
        for (int k = 0; k < 5; k++) begin
            chk("bp hold", {29'd0, rsp_valid, req_ready, rsp_fail}, 32'd4);
            chk("bp data_stable", rsp_data, 32'hCAFEF00D);
            tick();
        end
        dec_dbg_cmd_done = 1'b0; dec_dbg_cmd_fail = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("bp back_to_idle", {30'd0, req_ready, rsp_valid}, 32'd2);
        req_type = 2'd2; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("bp b2b_accepted", {30'd0, rsp_valid, rsp_fail}, 32'd3);
        tick();
        $display("txn backpressure rsp_valid=%0b req_ready=%0b", rsp_valid, req_ready);

        // Asynchronous reset while waiting on the core.
        req_type = 2'd0; req_addr = 32'd12; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("rstwait in_wait", {30'd0, dbg_cmd_valid, req_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rstwait outs", {30'd0, dbg_cmd_valid, rsp_valid}, 32'd0);
        chk("rstwait cmd_addr", dbg_cmd_addr, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        dec_dbg_cmd_done = 1'b1; dec_dbg_rddata = 32'h77777777;
        for (int k = 0; k < 3; k++) begin
            chk("rstwait no_stale", {30'd0, req_ready, rsp_valid}, 32'd2);
            tick();
        end
        dec_dbg_cmd_done = 1'b0;
        $display("txn reset_in_wait req_ready=%0b rsp_valid=%0b", req_ready, rsp_valid);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
